// File: rtl/bus_uart_pkg.sv
// Shared definitions for the memory-mapped UART: register map, STATUS layout,
// serial engine state encoding and the baud divisor clamp.
package bus_uart_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DIV    = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    localparam int STAT_RXNE   = 0;
    localparam int STAT_TXFULL = 1;
    localparam int STAT_TXIDLE = 2;
    localparam int STAT_OVR    = 3;
    localparam int STAT_FRM    = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    // A divisor below 2 would leave no room for a mid-bit sample point.
    function automatic logic [15:0] div_clamp(input logic [15:0] div);
        if (div < 16'd2) begin
            return 16'd2;
        end else begin
            return div;
        end
    endfunction

endpackage

// File: rtl/bus_uart_fifo.sv
// Byte FIFO used for both UART directions; full/empty reflect the state at the
// start of the cycle, so a push while full is refused even alongside a pop.
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty = (wptr_q == rptr_q);
    assign dout  = mem_q[rptr_q[AW-1:0]];

    // Pointer advance for accepted pushes and pops
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push && !full) begin
            wptr_d = wptr_q + PTR_ONE;
        end else begin
            wptr_d = wptr_q;
        end
        if (pop && !empty) begin
            rptr_d = rptr_q + PTR_ONE;
        end else begin
            rptr_d = rptr_q;
        end
    end

    // Pointer registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage array, written only on an accepted push
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem_q[wptr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/bus_uart.sv
// Memory-mapped UART slave: single-cycle bus register decode, TX/RX serial
// engines with byte FIFOs, sticky line-error flags and a level interrupt.
module bus_uart
    import bus_uart_pkg::*;
#(
    parameter int          FIFODEPTH = 16,
    parameter logic [15:0] DIVRESET  = 16'd868
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] busaddr,
    input  logic [31:0] buswdata,
    input  logic [3:0]  buswstrb,
    input  logic        buswr,
    input  logic        busreq,
    output logic [31:0] busrdata,
    output logic        busack,
    output logic        buserr,
    output logic        txd,
    input  logic        rxd,
    output logic        irq
);

    logic        ack_q, ack_d, err_q, err_d, irq_q, irq_d;
    logic [31:0] rdata_q, rdata_d, status_s;
    logic [15:0] div_q, div_d, div_eff_s;
    logic [1:0]  ctrl_q, ctrl_d;
    logic        ovr_q, ovr_d, frm_q, frm_d;
    logic        ovr_set_s, ovr_clr_s, frm_set_s, frm_clr_s;

    uart_state_e tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_sh_q, tx_sh_d;
    logic        txd_q, txd_d;

    uart_state_e rx_state_q, rx_state_d;
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_sh_q, rx_sh_d;
    logic        rx_s1_q, rx_s2_q, rx_prev_q;

    logic       tx_push_s, tx_pop_s, tx_full_s, tx_empty_s;
    logic       rx_push_s, rx_pop_s, rx_full_s, rx_empty_s;
    logic [7:0] tx_dout_s, rx_dout_s;
    logic       unused_s;

    assign unused_s  = ^{busaddr[31:12], busaddr[1:0], buswstrb[3:2], buswdata[31:16]};
    assign div_eff_s = div_clamp(div_q);

    assign busack   = ack_q;
    assign buserr   = err_q;
    assign busrdata = rdata_q;
    assign txd      = txd_q;
    assign irq      = irq_q;

    uart_fifo #(.WIDTH(8), .DEPTH(FIFODEPTH)) u_tx_fifo (
        .clk(clk), .rstn(rstn), .push(tx_push_s), .pop(tx_pop_s), .din(buswdata[7:0]),
        .dout(tx_dout_s), .full(tx_full_s), .empty(tx_empty_s)
    );

    uart_fifo #(.WIDTH(8), .DEPTH(FIFODEPTH)) u_rx_fifo (
        .clk(clk), .rstn(rstn), .push(rx_push_s), .pop(rx_pop_s), .din(rx_sh_q),
        .dout(rx_dout_s), .full(rx_full_s), .empty(rx_empty_s)
    );

    // STATUS word assembled from live FIFO/engine state and the sticky flags
    always_comb begin
        status_s              = 32'd0;
        status_s[STAT_RXNE]   = ~rx_empty_s;
        status_s[STAT_TXFULL] = tx_full_s;
        status_s[STAT_TXIDLE] = tx_empty_s & (tx_state_q == ST_IDLE);
        status_s[STAT_OVR]    = ovr_q;
        status_s[STAT_FRM]    = frm_q;
    end

    // Bus decode: register side effects and the response for the following cycle
    always_comb begin
        ack_d     = busreq;
        err_d     = 1'b0;
        rdata_d   = rdata_q;
        div_d     = div_q;
        ctrl_d    = ctrl_q;
        tx_push_s = 1'b0;
        rx_pop_s  = 1'b0;
        ovr_clr_s = 1'b0;
        frm_clr_s = 1'b0;
        if (!busreq) begin
            err_d = 1'b0;
        end else if (busaddr[11:4] != 8'd0) begin
            err_d   = 1'b1;
            rdata_d = buswr ? rdata_q : 32'd0;
        end else begin
            case (busaddr[3:2])
                REG_DATA: begin
                    if (buswr) begin
                        err_d     = buswstrb[0] & tx_full_s;
                        tx_push_s = buswstrb[0] & ~tx_full_s;
                    end else if (!rx_empty_s) begin
                        rdata_d  = {1'b1, 23'd0, rx_dout_s};
                        rx_pop_s = 1'b1;
                    end else begin
                        rdata_d = 32'd0;
                    end
                end
                REG_STATUS: begin
                    if (buswr) begin
                        ovr_clr_s = buswdata[STAT_OVR];
                        frm_clr_s = buswdata[STAT_FRM];
                    end else begin
                        rdata_d = status_s;
                    end
                end
                REG_DIV: begin
                    if (buswr) begin
                        div_d[7:0]  = buswstrb[0] ? buswdata[7:0]  : div_q[7:0];
                        div_d[15:8] = buswstrb[1] ? buswdata[15:8] : div_q[15:8];
                    end else begin
                        rdata_d = {16'd0, div_q};
                    end
                end
                REG_CTRL: begin
                    if (buswr) begin
                        ctrl_d = buswdata[1:0];
                    end else begin
                        rdata_d = {30'd0, ctrl_q};
                    end
                end
                default: err_d = 1'b1;
            endcase
        end
    end

    // TX engine; bit timers count down from DIV and advance when they reach 1
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_sh_d    = tx_sh_q;
        txd_d      = txd_q;
        tx_pop_s   = 1'b0;
        case (tx_state_q)
            ST_IDLE: begin
                txd_d = 1'b1;
                if (!tx_empty_s) begin
                    tx_pop_s   = 1'b1;
                    tx_sh_d    = tx_dout_s;
                    txd_d      = 1'b0;
                    tx_cnt_d   = div_eff_s;
                    tx_state_d = ST_START;
                end else begin
                    tx_state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (tx_cnt_q == 16'd1) begin
                    tx_state_d = ST_DATA;
                    txd_d      = tx_sh_q[0];
                    tx_bit_d   = 3'd0;
                    tx_cnt_d   = div_eff_s;
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
            ST_DATA: begin
                if (tx_cnt_q != 16'd1) begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end else if (tx_bit_q == 3'd7) begin
                    tx_state_d = ST_STOP;
                    txd_d      = 1'b1;
                    tx_cnt_d   = div_eff_s;
                end else begin
                    tx_bit_d = tx_bit_q + 3'd1;
                    tx_sh_d  = {1'b0, tx_sh_q[7:1]};
                    txd_d    = tx_sh_q[1];
                    tx_cnt_d = div_eff_s;
                end
            end
            ST_STOP: begin
                if (tx_cnt_q != 16'd1) begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end else if (!tx_empty_s) begin
                    // Waiting data starts the next frame straight after the stop bit
                    tx_pop_s   = 1'b1;
                    tx_sh_d    = tx_dout_s;
                    txd_d      = 1'b0;
                    tx_cnt_d   = div_eff_s;
                    tx_state_d = ST_START;
                end else begin
                    tx_state_d = ST_IDLE;
                end
            end
            default: begin
                tx_state_d = ST_IDLE;
                txd_d      = 1'b1;
            end
        endcase
    end

    // RX engine on the synchronised line; start detection arms a half-bit timer
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_sh_d    = rx_sh_q;
        rx_push_s  = 1'b0;
        ovr_set_s  = 1'b0;
        frm_set_s  = 1'b0;
        case (rx_state_q)
            ST_IDLE: begin
                if (rx_prev_q && !rx_s2_q) begin
                    rx_state_d = ST_START;
                    rx_cnt_d   = div_eff_s >> 1;
                end else begin
                    rx_state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (rx_cnt_q != 16'd1) begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end else if (rx_s2_q) begin
                    rx_state_d = ST_IDLE;
                end else begin
                    rx_state_d = ST_DATA;
                    rx_bit_d   = 3'd0;
                    rx_cnt_d   = div_eff_s;
                end
            end
            ST_DATA: begin
                if (rx_cnt_q != 16'd1) begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end else begin
                    rx_sh_d    = {rx_s2_q, rx_sh_q[7:1]};
                    rx_cnt_d   = div_eff_s;
                    rx_bit_d   = rx_bit_q + 3'd1;
                    rx_state_d = (rx_bit_q == 3'd7) ? ST_STOP : ST_DATA;
                end
            end
            ST_STOP: begin
                if (rx_cnt_q != 16'd1) begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end else begin
                    rx_state_d = ST_IDLE;
                    frm_set_s  = ~rx_s2_q;
                    ovr_set_s  = rx_s2_q & rx_full_s;
                    rx_push_s  = rx_s2_q & ~rx_full_s;
                end
            end
            default: rx_state_d = ST_IDLE;
        endcase
    end

    // Sticky flags (a set beats a simultaneous clear) and the interrupt level
    always_comb begin
        ovr_d = ovr_set_s | (ovr_q & ~ovr_clr_s);
        frm_d = frm_set_s | (frm_q & ~frm_clr_s);
        irq_d = (ctrl_q[0] & ~rx_empty_s) | (ctrl_q[1] & tx_empty_s) | ovr_q | frm_q;
    end

    // All block state
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= 32'd0;
            irq_q      <= 1'b0;
            div_q      <= DIVRESET;
            ctrl_q     <= 2'd0;
            ovr_q      <= 1'b0;
            frm_q      <= 1'b0;
            tx_state_q <= ST_IDLE;
            tx_cnt_q   <= 16'd0;
            tx_bit_q   <= 3'd0;
            tx_sh_q    <= 8'd0;
            txd_q      <= 1'b1;
            rx_state_q <= ST_IDLE;
            rx_cnt_q   <= 16'd0;
            rx_bit_q   <= 3'd0;
            rx_sh_q    <= 8'd0;
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
        end else begin
            ack_q      <= ack_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            irq_q      <= irq_d;
            div_q      <= div_d;
            ctrl_q     <= ctrl_d;
            ovr_q      <= ovr_d;
            frm_q      <= frm_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_sh_q    <= tx_sh_d;
            txd_q      <= txd_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_sh_q    <= rx_sh_d;
            rx_s1_q    <= rxd;
            rx_s2_q    <= rx_s1_q;
            rx_prev_q  <= rx_s2_q;
        end
    end

endmodule

// File: tb/tb_bus_uart.sv
// Self-checking bench for bus_uart: random serial traffic checked against a
// queue-based model of the register file, RX FIFO and sticky flags.
module tb_bus_uart;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] busaddr = 32'd0;
    logic [31:0] buswdata = 32'd0;
    logic [3:0]  buswstrb = 4'd0;
    logic        buswr = 1'b0;
    logic        busreq = 1'b0;
    logic [31:0] busrdata;
    logic        busack, buserr, txd, irq;
    logic        rxd_drv = 1'b1;
    logic        loop_en = 1'b0;
    logic        rxd;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] m_div;
    logic [1:0]  m_ctrl;
    logic        m_ovr, m_frm;
    logic [7:0]  m_rxq [$];

    assign rxd = loop_en ? txd : rxd_drv;

    bus_uart #(.FIFODEPTH(DEPTH), .DIVRESET(16'd868)) dut (
        .clk(clk), .rstn(rstn), .busaddr(busaddr), .buswdata(buswdata), .buswstrb(buswstrb),
        .buswr(buswr), .busreq(busreq), .busrdata(busrdata), .busack(busack), .buserr(buserr),
        .txd(txd), .rxd(rxd), .irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_div  = 16'd868;
        m_ctrl = 2'd0;
        m_ovr  = 1'b0;
        m_frm  = 1'b0;
        m_rxq.delete();
    endfunction

    // A received frame: bad stop bit -> framing, full FIFO -> overrun, else stored
    function automatic void model_rx_frame(input logic [7:0] b, input logic stop_ok);
        if (!stop_ok) m_frm = 1'b1;
        else if (m_rxq.size() == DEPTH) m_ovr = 1'b1;
        else m_rxq.push_back(b);
    endfunction

    // Checkpoints are only taken with the transmitter drained and idle
    function automatic logic [31:0] exp_status();
        return {27'd0, m_frm, m_ovr, 1'b1, 1'b0, m_rxq.size() != 0};
    endfunction

    function automatic logic exp_irq();
        return (m_ctrl[0] && m_rxq.size() != 0) || m_ctrl[1] || m_ovr || m_frm;
    endfunction

    task automatic wr_chk(input string tag, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input logic exp_err);
        @(negedge clk);
        busreq = 1'b1; buswr = 1'b1; busaddr = addr; buswdata = data; buswstrb = strb;
        @(negedge clk);
        busreq = 1'b0; buswr = 1'b0;
        check_eq({tag, "_ack"}, {31'd0, busack}, 32'd1);
        check_eq({tag, "_err"}, {31'd0, buserr}, {31'd0, exp_err});
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp,
                          input logic exp_err);
        @(negedge clk);
        busreq = 1'b1; buswr = 1'b0; busaddr = addr; buswstrb = 4'h0;
        @(negedge clk);
        busreq = 1'b0;
        check_eq({tag, "_ack"}, {31'd0, busack}, 32'd1);
        check_eq({tag, "_err"}, {31'd0, buserr}, {31'd0, exp_err});
        if (!exp_err) check_eq(tag, busrdata, exp);
    endtask

    task automatic rd_data_chk(input string tag);
        logic [31:0] e;
        if (m_rxq.size() != 0) e = {1'b1, 23'd0, m_rxq.pop_front()};
        else e = 32'd0;
        rd_chk(tag, 32'h0, e, 1'b0);
    endtask

    // Drives one frame on rxd, each bit held div clocks
    task automatic send_frame(input logic [7:0] b, input logic stop, input int div);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rxd_drv = f[i];
            repeat (div - 1) @(negedge clk);
        end
        @(negedge clk);
        rxd_drv = 1'b1;
    endtask

    // Call on a negedge; waits for a start bit, records 10 bit-times and
    // counts every cycle that disagrees with its bit's mid-point level.
    task automatic capture_tx(input int div, output logic [7:0] b, output int bad);
        logic       samp [0:159];
        logic [9:0] lv;
        int         guard;
        int         d;
        d = (div < 2) ? 2 : div;
        guard = 0; bad = 0; b = 8'h00; lv = 10'd0;
        while (txd !== 1'b0 && guard < 4000) begin
            @(negedge clk);
            guard++;
        end
        if (txd !== 1'b0) begin
            bad = 1000;
        end else begin
            for (int c = 0; c < 10 * d; c++) begin
                samp[c] = txd;
                @(negedge clk);
            end
            for (int i = 0; i < 10; i++) lv[i] = samp[i * d + d / 2];
            for (int c = 0; c < 10 * d; c++) if (samp[c] !== lv[c / d]) bad++;
            if (lv[0] !== 1'b0) bad++;
            if (lv[9] !== 1'b1) bad++;
            b = lv[8:1];
        end
    endtask

    initial begin
        logic [7:0] got_b;
        int         bad;
        int         lows;
        logic [7:0] bb [0:17];
        logic [7:0] rq [$];

        model_reset();
        repeat (3) @(negedge clk);
        check_eq("rst_txd", {31'd0, txd}, 32'd1);
        check_eq("rst_ack", {31'd0, busack}, 32'd0);
        check_eq("rst_irq", {31'd0, irq}, 32'd0);
        check_eq("rst_rdata", busrdata, 32'd0);
        rstn = 1'b1;

        rd_chk("div_reset", 32'h8, 32'd868, 1'b0);
        wr_chk("ctrl_wr0", 32'hC, 32'd0, 4'hF, 1'b0);
        check_eq("rdata_hold", busrdata, 32'd868);
        rd_chk("status_reset", 32'h4, exp_status(), 1'b0);

        // Out-of-range addresses error with no side effect
        rd_chk("bad_rd", 32'h10, 32'd0, 1'b1);
        wr_chk("bad_wr", 32'h18, 32'hFFFF_FFFF, 4'hF, 1'b1);
        wr_chk("bad_wr2", 32'h80C, 32'h3, 4'hF, 1'b1);
        rd_chk("div_after_bad", 32'h8, {16'd0, m_div}, 1'b0);
        rd_chk("ctrl_after_bad", 32'hC, {30'd0, m_ctrl}, 1'b0);

        // Byte strobes on DIV
        wr_chk("div_wr4", 32'h8, 32'd4, 4'h3, 1'b0);
        m_div = 16'd4;
        wr_chk("div_strb", 32'h8, 32'h0000_1234, 4'h2, 1'b0);
        m_div[15:8] = 8'h12;
        rd_chk("div_strb_rd", 32'h8, {16'd0, m_div}, 1'b0);
        wr_chk("div_wr4b", 32'h8, 32'd4, 4'h3, 1'b0);
        m_div = 16'd4;

        // DATA write without byte 0 enabled is a no-op
        wr_chk("data_nostrb", 32'h0, 32'h55, 4'hE, 1'b0);
        lows = 0;
        repeat (30) begin
            @(negedge clk);
            if (txd === 1'b0) lows++;
        end
        check_eq("nostrb_txd_quiet", lows, 32'd0);
        rd_chk("nostrb_status", 32'h4, exp_status(), 1'b0);

        // Loopback of 0x41 at DIV=4
        loop_en = 1'b1;
        fork
            wr_chk("tx41_wr", 32'h0, 32'h41, 4'h1, 1'b0);
            begin
                @(negedge clk);
                capture_tx(4, got_b, bad);
                check_eq("tx41_byte", {24'd0, got_b}, 32'h41);
                check_eq("tx41_timing", bad, 32'd0);
            end
        join
        model_rx_frame(8'h41, 1'b1);
        repeat (10) @(negedge clk);
        rd_data_chk("rx41_rd");
        rd_data_chk("rx41_empty_rd");

        // Random loopback rounds, including divisors that clamp to 2
        for (int r = 0; r < 4; r++) begin
            int          n;
            logic [15:0] dv;
            dv = (r == 0) ? 16'd0 : (r == 1) ? 16'd1 : 16'($urandom_range(3, 9));
            n  = $urandom_range(3, 8);
            wr_chk("rnd_div_wr", 32'h8, {16'd0, dv}, 4'h3, 1'b0);
            m_div = dv;
            rd_chk("rnd_div_rd", 32'h8, {16'd0, m_div}, 1'b0);
            rq.delete();
            for (int i = 0; i < n; i++) rq.push_back(8'($urandom_range(0, 255)));
            fork
                begin
                    for (int i = 0; i < n; i++) wr_chk("rnd_tx_wr", 32'h0, {24'd0, rq[i]}, 4'h1, 1'b0);
                end
                begin
                    @(negedge clk);
                    for (int i = 0; i < n; i++) begin
                        capture_tx(int'(dv), got_b, bad);
                        check_eq("rnd_tx_byte", {24'd0, got_b}, {24'd0, rq[i]});
                        check_eq("rnd_tx_timing", bad, 32'd0);
                    end
                end
            join
            for (int i = 0; i < n; i++) model_rx_frame(rq[i], 1'b1);
            repeat (12) @(negedge clk);
            rd_chk("rnd_status", 32'h4, exp_status(), 1'b0);
            for (int i = 0; i <= n; i++) rd_data_chk("rnd_rx_rd");
        end
        loop_en = 1'b0;

        // 18 back-to-back DATA writes: FIFO plus the shifter absorb 17
        wr_chk("bb_div", 32'h8, 32'd4, 4'h3, 1'b0);
        m_div = 16'd4;
        for (int i = 0; i < 18; i++) bb[i] = 8'($urandom_range(0, 255));
        fork
            begin
                for (int k = 0; k <= 18; k++) begin
                    @(negedge clk);
                    if (k > 0) begin
                        check_eq("bb_ack", {31'd0, busack}, 32'd1);
                        check_eq("bb_err", {31'd0, buserr}, {31'd0, (k - 1) >= DEPTH + 1});
                    end
                    if (k < 18) begin
                        busreq = 1'b1; buswr = 1'b1; busaddr = 32'h0;
                        buswdata = {24'd0, bb[k]}; buswstrb = 4'h1;
                    end else begin
                        busreq = 1'b0; buswr = 1'b0;
                    end
                end
            end
            begin
                @(negedge clk);
                for (int f = 0; f < DEPTH + 1; f++) begin
                    capture_tx(4, got_b, bad);
                    check_eq("bb_tx_byte", {24'd0, got_b}, {24'd0, bb[f]});
                    check_eq("bb_tx_timing", bad, 32'd0);
                end
            end
        join
        lows = 0;
        repeat (80) begin
            @(negedge clk);
            if (txd === 1'b0) lows++;
        end
        check_eq("bb_no_18th_frame", lows, 32'd0);
        rd_chk("bb_status", 32'h4, exp_status(), 1'b0);

        // Framing error on a bad stop bit, then write-1-to-clear
        send_frame(8'h5A, 1'b0, 4);
        model_rx_frame(8'h5A, 1'b0);
        repeat (8) @(negedge clk);
        rd_chk("frm_status", 32'h4, exp_status(), 1'b0);
        check_eq("frm_irq", {31'd0, irq}, {31'd0, exp_irq()});
        wr_chk("frm_clr", 32'h4, 32'h10, 4'h1, 1'b0);
        m_frm = 1'b0;
        repeat (2) @(negedge clk);
        rd_chk("frm_cleared", 32'h4, exp_status(), 1'b0);
        check_eq("frm_irq_clr", {31'd0, irq}, {31'd0, exp_irq()});

        // A one-clock low pulse is a glitch, not a start bit
        @(negedge clk); rxd_drv = 1'b0;
        @(negedge clk); rxd_drv = 1'b1;
        repeat (60) @(negedge clk);
        rd_chk("glitch_status", 32'h4, exp_status(), 1'b0);

        // Interrupt enables
        wr_chk("ctrl_txie", 32'hC, 32'h2, 4'h1, 1'b0);
        m_ctrl = 2'd2;
        rd_chk("ctrl_rd", 32'hC, {30'd0, m_ctrl}, 1'b0);
        check_eq("txie_irq", {31'd0, irq}, {31'd0, exp_irq()});
        wr_chk("ctrl_rxie", 32'hC, 32'h1, 4'h1, 1'b0);
        m_ctrl = 2'd1;
        repeat (2) @(negedge clk);
        check_eq("rxie_irq_idle", {31'd0, irq}, {31'd0, exp_irq()});
        send_frame(8'h3C, 1'b1, 4);
        model_rx_frame(8'h3C, 1'b1);
        repeat (8) @(negedge clk);
        check_eq("rxie_irq_data", {31'd0, irq}, {31'd0, exp_irq()});
        rd_data_chk("rxie_rd");
        repeat (2) @(negedge clk);
        check_eq("rxie_irq_drained", {31'd0, irq}, {31'd0, exp_irq()});
        wr_chk("ctrl_off", 32'hC, 32'h0, 4'h1, 1'b0);
        m_ctrl = 2'd0;

        // Overrun: 17 frames into a 16-deep RX FIFO
        rq.delete();
        for (int i = 0; i < DEPTH + 1; i++) rq.push_back(8'($urandom_range(0, 255)));
        for (int i = 0; i < DEPTH + 1; i++) begin
            send_frame(rq[i], 1'b1, 4);
            model_rx_frame(rq[i], 1'b1);
        end
        repeat (8) @(negedge clk);
        rd_chk("ovr_status", 32'h4, exp_status(), 1'b0);
        check_eq("ovr_irq", {31'd0, irq}, {31'd0, exp_irq()});
        for (int i = 0; i < DEPTH; i++) rd_data_chk("ovr_rx_rd");
        wr_chk("ovr_clr", 32'h4, 32'h08, 4'h1, 1'b0);
        m_ovr = 1'b0;
        repeat (2) @(negedge clk);
        rd_chk("ovr_cleared", 32'h4, exp_status(), 1'b0);
        check_eq("ovr_irq_clr", {31'd0, irq}, {31'd0, exp_irq()});

        // Reset in the middle of a frame drops txd high at once
        wr_chk("mid_div", 32'h8, 32'd100, 4'h3, 1'b0);
        wr_chk("mid_data", 32'h0, 32'hA5, 4'h1, 1'b0);
        repeat (20) @(negedge clk);
        check_eq("mid_start_low", {31'd0, txd}, 32'd0);
        rstn = 1'b0;
        #1;
        check_eq("mid_rst_txd", {31'd0, txd}, 32'd1);
        check_eq("mid_rst_ack", {31'd0, busack}, 32'd0);
        check_eq("mid_rst_irq", {31'd0, irq}, 32'd0);
        model_reset();
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        rd_chk("post_rst_div", 32'h8, {16'd0, m_div}, 1'b0);
        rd_chk("post_rst_status", 32'h4, exp_status(), 1'b0);
        rd_chk("post_rst_ctrl", 32'hC, {30'd0, m_ctrl}, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
